// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              borrow_q, borrow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;

  logic x, y, c, res_bit, borrow_nxt;

  assign x          = a_q[0];
  assign y          = b_q[0];
  assign c          = borrow_q;
  assign res_bit    = x ^ y ^ c;
  assign borrow_nxt = (~x & y) | (~x & c) | (y & c);

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are kept because a_q/b_q are shifted away during the operation.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          res_d    = '0;
          cnt_d    = '0;
          state_d  = StShift;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
`endif
        end
      end
      StShift: begin
        res_d    = (res_q >> 1) | (WIDTH'(res_bit) << (WIDTH - 1));
        borrow_d = borrow_nxt;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          diff_d  = res_d;
          bout_d  = borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (res_bit != a_msb_q);
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub (WIDTH=4) against hand-computed results.
// Define SERIAL_SUB_OVF_EN to also check the ovf output.
module tb_serial_sub;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;
  int rnd_bad  = 0;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start one operation and return in the done cycle; operands are scrambled after acceptance.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tbin, input string tag);
    int lat;
    int busy_cnt;
    int guard;
    guard = 0;
    while ((busy || done) && guard < 20) begin
      step(1);
      guard++;
    end
    a     = ta;
    b     = tb_v;
    bin   = tbin;
    start = 1'b1;
    step(1);
    start    = 1'b0;
    a        = ~ta;
    b        = ~tb_v;
    bin      = ~tbin;
    lat      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      step(1);
      lat++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, lat, WIDTH);
    check({tag, "_busy"}, busy_cnt, WIDTH);
  endtask

  initial begin
    int d0;
    logic [WIDTH-1:0] ra, rb;
    logic             rbin;
    logic [WIDTH:0]   e;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    step(3);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done_cnt", done_cnt, 0);

    // 9 - 3 - 0 = 6
    run_op(4'd9, 4'd3, 1'b0, "op9_3");
    check("op9_3_diff", 32'(diff), 32'd6);
    check("op9_3_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("op9_3_ovf", 32'(ovf), 32'd1);
`endif
    step(3);
    check("hold_diff", 32'(diff), 32'd6);
    check("hold_bout", 32'(bout), 32'd0);
    check("hold_done", 32'(done), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);

    run_op(4'd3, 4'd9, 1'b0, "op3_9");
    check("op3_9_diff", 32'(diff), 32'd10);
    check("op3_9_bout", 32'(bout), 32'd1);

    run_op(4'd0, 4'd0, 1'b1, "op0_0_1");
    check("op0_0_1_diff", 32'(diff), 32'd15);
    check("op0_0_1_bout", 32'(bout), 32'd1);

    run_op(4'd15, 4'd15, 1'b1, "op15_15_1");
    check("op15_15_1_diff", 32'(diff), 32'd15);
    check("op15_15_1_bout", 32'(bout), 32'd1);

    // Start asserted mid-operation must be ignored
    step(1);
    d0    = done_cnt;
    a     = 4'd12;
    b     = 4'd5;
    bin   = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    start = 1'b1;
    a     = 4'd0;
    b     = 4'd0;
    step(1);
    start = 1'b0;
    begin
      int g;
      g = 0;
      while (done !== 1'b1 && g < 20) begin
        step(1);
        g++;
      end
    end
    check("ign_done", 32'(done), 32'd1);
    check("ign_diff", 32'(diff), 32'd7);
    check("ign_bout", 32'(bout), 32'd0);
    step(3);
    check("ign_pulses", done_cnt - d0, 1);
    check("ign_busy", 32'(busy), 32'd0);

    // Reset mid-operation discards the result
    d0    = done_cnt;
    a     = 4'd9;
    b     = 4'd3;
    bin   = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_diff", 32'(diff), 32'd0);
    check("mrst_bout", 32'(bout), 32'd0);
    step(6);
    check("mrst_no_done", done_cnt - d0, 0);

    run_op(4'd5, 4'd2, 1'b1, "op5_2_1");
    check("op5_2_1_diff", 32'(diff), 32'd2);
    check("op5_2_1_bout", 32'(bout), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
    run_op(4'd8, 4'd1, 1'b0, "ovf8_1");
    check("ovf8_1_diff", 32'(diff), 32'd7);
    check("ovf8_1_ovf", 32'(ovf), 32'd1);
    run_op(4'd7, 4'd15, 1'b0, "ovf7_15");
    check("ovf7_15_diff", 32'(diff), 32'd8);
    check("ovf7_15_ovf", 32'(ovf), 32'd1);
    check("ovf7_15_bout", 32'(bout), 32'd1);
    run_op(4'd5, 4'd2, 1'b0, "ovf5_2");
    check("ovf5_2_ovf", 32'(ovf), 32'd0);
`endif

    for (int i = 0; i < 1000; i++) begin
      int f0;
      ra   = WIDTH'($urandom_range(0, 15));
      rb   = WIDTH'($urandom_range(0, 15));
      rbin = 1'($urandom_range(0, 1));
      e    = {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rbin};
      f0   = fails;
      run_op(ra, rb, rbin, "rnd");
      check("rnd_res", 32'({bout, diff}), 32'(e));
`ifdef SERIAL_SUB_OVF_EN
      check("rnd_ovf", 32'(ovf), 32'((ra[WIDTH-1] != rb[WIDTH-1]) && (e[WIDTH-1] != ra[WIDTH-1])));
`endif
      if (fails != f0) rnd_bad++;
    end
    if (rnd_bad == 0) $display("Success");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial subtractor: computes a - b - bin LSB-first, one bit per clock, with a start/busy/done handshake.
- Inverse counterpart of the team's combinational adder; uses the same operand/carry-style port set (a, b, borrow-in, result, borrow-out).
- Used in low-area datapaths and as a self-checking companion to the adder: (a + b + cin) followed by subtracting b and cin must return a.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse; diff/bout valid from this cycle on.
- diff  output  WIDTH  difference; held until the next completed operation.
- bout  output  1  borrow-out; held with diff.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset, on an edge with rst=1:
  - state=IDLE; busy=0, done=0, diff=0, bout=0 (ovf=0 if present).
  - Internal shift registers and the bit counter are cleared.
  - rst overrides every other input, including mid-operation; a partial result is discarded and no done pulse is issued.
- IDLE:
  - start=1 at edge E0: latch a, b, bin into internal registers; borrow register = bin; counter = 0; go to SHIFT.
  - start=0: stay in IDLE; outputs keep their last values.
- SHIFT: on each edge, with x = a_reg[0], y = b_reg[0], c = borrow:
  - result bit = x ^ y ^ c, shifted into the MSB of the result register (right-shift, so bit i lands at position i after WIDTH shifts).
  - borrow <= (~x & y) | (~x & c) | (y & c).
  - a_reg and b_reg shift right by 1; counter increments.
  - WIDTH shift edges (E1..E_WIDTH); at E_WIDTH move to DONE.
- DONE:
  - diff = result register, bout = final borrow, done=1 for exactly this one cycle, busy=0.
  - Next edge: return to IDLE unconditionally.
- Handshake and latency:
  - busy is high from the cycle after E0 through the cycle after E_(WIDTH-1); that is WIDTH cycles.
  - done is high in the cycle after E_WIDTH; latency from start to done is WIDTH+1 edges.
  - start is ignored while in SHIFT or DONE. There is no queuing; the earliest new start is accepted in the first IDLE cycle after DONE.
  - diff/bout change only on entry to DONE or on reset; they are stable for the whole gap between operations.
- Arithmetic:
  - Unsigned result satisfies a - b - bin = diff - bout * 2^WIDTH.
  - bout=1 exactly when a < b + bin.
  - Wrap-around is modulo 2^WIDTH (e.g. 0 - 0 - 1 gives all ones with bout=1).
- Input changes on a, b, bin after the accepted start have no effect on the operation in flight.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Extra output port ovf (output, 1): two's-complement signed overflow of a - b - bin.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), computed from the latched operands.
  - Updated together with diff/bout on entry to DONE; 0 on reset.
- Undefined:
  - Port ovf is absent and no overflow logic is synthesized.
  - All other behaviour is identical.

Test Plan:
- WIDTH=4, rst=1 for 2 cycles, then release -> busy=0, done=0, diff=0, bout=0; no activity without start.
- start with a=9, b=3, bin=0 -> busy high for 4 cycles; done pulses 5 edges after start; diff=6, bout=0; held afterwards.
- Borrow and wrap-around cases:
  - a=3, b=9, bin=0 -> diff=10, bout=1.
  - a=0, b=0, bin=1 -> diff=15, bout=1.
  - a=15, b=15, bin=1 -> diff=15, bout=1.
- a=12, b=5 started; at cycle 2 start=1 and a=0, b=0 -> start ignored; result diff=7, bout=0; exactly one done pulse.
- rst=1 at cycle 2 of an operation with a=9, b=3 -> next cycle busy=0, diff=0, no done. A fresh start with a=5, b=2, bin=1 then yields diff=2, bout=0.
- With SERIAL_SUB_OVF_EN defined:
  - a=8, b=1, bin=0 -> diff=7, ovf=1.
  - a=7, b=15, bin=0 -> diff=8, ovf=1, bout=1.
  - a=5, b=2, bin=0 -> ovf=0.
- Random check: 1000 random {a, b, bin} -> {bout, diff} always matches a - b - bin modulo 2^(WIDTH+1). The bench counts mismatches and prints "Success" only when the count is zero.
